// File: rtl/perf_cnt_bank_pkg.sv
// Shared definitions for the performance counter bank: snapshot FSM
// encoding, counter widths and the default decimal wrap limit.
package perf_cnt_bank_pkg;

    // The low counter is always a full 32-bit word.
    localparam int unsigned LO_W = 32;

    // Nine decimal digits: the low word rolls over at one billion events.
    localparam logic [LO_W-1:0] LO_MAX_DEFAULT = 32'd999_999_999;

    // Snapshot FSM: live reads in IDLE, shadow reads while HOLD.
    typedef enum logic {
        SNAP_IDLE = 1'b0,
        SNAP_HOLD = 1'b1
    } snap_state_e;

    // Width of a channel select, never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perf_cnt_chan.sv
// One event channel: a low counter that wraps at LO_MAX and carries into a
// high counter, plus a sticky overflow flag set when the high counter wraps.
module perf_cnt_chan
    import perf_cnt_bank_pkg::*;
#(
    parameter logic [LO_W-1:0] LO_MAX = LO_MAX_DEFAULT,
    parameter int unsigned     HI_W   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_i,
    input  logic            clr_i,
    output logic [LO_W-1:0] lo_o,
    output logic [HI_W-1:0] hi_o,
    output logic            ovf_o
);

    logic [LO_W-1:0] lo_q, lo_d;
    logic [HI_W-1:0] hi_q, hi_d;
    logic            ovf_q, ovf_d;

    // Next-state: clear has priority over a same-cycle increment.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        lo_d  = lo_q;
        hi_d  = hi_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            lo_d  = '0;
            hi_d  = '0;
            ovf_d = 1'b0;
        end else if (inc_i) begin
            if (lo_q == LO_MAX) begin
                lo_d = '0;
                hi_d = hi_q + 1'b1;
                if (hi_q == '1) begin
                    ovf_d = 1'b1;
                end
            end else begin
                lo_d = lo_q + 1'b1;
            end
        end
    end

    // Counter state register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every register
        // samples values from before the edge, independent of block order.
        if (rst) begin
            lo_q  <= '0;
            hi_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            lo_q  <= lo_d;
            hi_q  <= hi_d;
            ovf_q <= ovf_d;
        end
    end

    assign lo_o  = lo_q;
    assign hi_o  = hi_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_cnt_bank.sv
// Bank of NUM_CH performance counters with an atomic snapshot of all
// channels and a registered per-channel read port.
module perf_cnt_bank
    import perf_cnt_bank_pkg::*;
#(
    parameter int              NUM_CH = 16,
    parameter logic [LO_W-1:0] LO_MAX = LO_MAX_DEFAULT,
    parameter int unsigned     HI_W   = 32,
    localparam int unsigned    SEL_W  = sel_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ev_inc,
    input  logic              freeze,
    input  logic              clr_en,
    input  logic [NUM_CH-1:0] clr_mask,
    input  logic              snap_req,
    input  logic              snap_ack,
    output logic              snap_valid,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [LO_W-1:0]   rd_lo,
    output logic [HI_W-1:0]   rd_hi,
    output logic [NUM_CH-1:0] ovf
);

    logic [LO_W-1:0] lo_live [NUM_CH];
    logic [HI_W-1:0] hi_live [NUM_CH];
    logic [LO_W-1:0] lo_shadow_q [NUM_CH];
    logic [HI_W-1:0] hi_shadow_q [NUM_CH];

    snap_state_e     state_q, state_d;
    logic            capture;
    logic [LO_W-1:0] rd_lo_q, rd_lo_d;
    logic [HI_W-1:0] rd_hi_q, rd_hi_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        perf_cnt_chan #(
            .LO_MAX (LO_MAX),
            .HI_W   (HI_W)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .inc_i (ev_inc[g] & ~freeze),
            .clr_i (clr_en & clr_mask[g]),
            .lo_o  (lo_live[g]),
            .hi_o  (hi_live[g]),
            .ovf_o (ovf[g])
        );
    end

    // Snapshot FSM next state: capture on request in IDLE, release on ack in HOLD.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            SNAP_IDLE: begin
                if (snap_req) begin
                    capture = 1'b1;
                    state_d = SNAP_HOLD;
                end
            end
            SNAP_HOLD: begin
                if (snap_ack) begin
                    state_d = SNAP_IDLE;
                end
            end
            default: state_d = SNAP_IDLE;
        endcase
    end

    // Snapshot FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SNAP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shadow copy of all channels, taken from the pre-edge live counts.
    always_ff @(posedge clk) begin
        // NOTE: this storage array is reset on purpose: a snapshot taken right
        // after reset must read back as zeros, not as stale data.
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                lo_shadow_q[i] <= '0;
                hi_shadow_q[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_CH; i++) begin
                lo_shadow_q[i] <= lo_live[i];
                hi_shadow_q[i] <= hi_live[i];
            end
        end
    end

    // Read mux: shadow while holding, live otherwise, zero for absent channels.
    always_comb begin
        rd_lo_d = '0;
        rd_hi_d = '0;
        if (int'(rd_sel) < NUM_CH) begin
            if (state_q == SNAP_HOLD) begin
                rd_lo_d = lo_shadow_q[rd_sel];
                rd_hi_d = hi_shadow_q[rd_sel];
            end else begin
                rd_lo_d = lo_live[rd_sel];
                rd_hi_d = hi_live[rd_sel];
            end
        end
    end

    // Registered read data, one cycle behind rd_sel.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_lo_q <= '0;
            rd_hi_q <= '0;
        end else begin
            rd_lo_q <= rd_lo_d;
            rd_hi_q <= rd_hi_d;
        end
    end

    assign rd_lo      = rd_lo_q;
    assign rd_hi      = rd_hi_q;
    assign snap_valid = (state_q == SNAP_HOLD);

endmodule

// File: tb/tb_perf_cnt_bank.sv
// Scoreboard bench for perf_cnt_bank. The reference model keeps one running
// event total per channel and derives lo/hi/ovf from it arithmetically.
// A second instance with three channels exercises out-of-range selects.
module tb_perf_cnt_bank;

    localparam int NCH     = 4;
    localparam int LO_MOD  = 10;   // LO_MAX + 1
    localparam int HI_MOD  = 4;    // 2**HI_W
    localparam int OVF_AT  = LO_MOD * HI_MOD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ev_inc = '0;
    logic        freeze = 1'b0;
    logic        clr_en = 1'b0;
    logic [3:0]  clr_mask = '0;
    logic        snap_req = 1'b0;
    logic        snap_ack = 1'b0;
    logic [1:0]  rd_sel = '0;

    logic        snap_valid;
    logic [31:0] rd_lo;
    logic [1:0]  rd_hi;
    logic [3:0]  ovf;

    logic        snap_valid_b;
    logic [31:0] rd_lo_b;
    logic [1:0]  rd_hi_b;
    logic [2:0]  ovf_b;
    logic [2:0]  ev_inc_b;
    logic [2:0]  clr_mask_b;

    assign ev_inc_b   = ev_inc[2:0];
    assign clr_mask_b = clr_mask[2:0];

    int n_checks = 0;
    int n_errors = 0;

    perf_cnt_bank #(.NUM_CH(4), .LO_MAX(32'd9), .HI_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .ev_inc     (ev_inc),
        .freeze     (freeze),
        .clr_en     (clr_en),
        .clr_mask   (clr_mask),
        .snap_req   (snap_req),
        .snap_ack   (snap_ack),
        .snap_valid (snap_valid),
        .rd_sel     (rd_sel),
        .rd_lo      (rd_lo),
        .rd_hi      (rd_hi),
        .ovf        (ovf)
    );

    perf_cnt_bank #(.NUM_CH(3), .LO_MAX(32'd9), .HI_W(2)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .ev_inc     (ev_inc_b),
        .freeze     (freeze),
        .clr_en     (clr_en),
        .clr_mask   (clr_mask_b),
        .snap_req   (snap_req),
        .snap_ack   (snap_ack),
        .snap_valid (snap_valid_b),
        .rd_sel     (rd_sel),
        .rd_lo      (rd_lo_b),
        .rd_hi      (rd_hi_b),
        .ovf        (ovf_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lo;
        logic [1:0]  hi;
        logic [31:0] lo_b;
        logic [1:0]  hi_b;
        logic        sv;
        logic [3:0]  ovf;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: event totals since last clear/reset, plus snapshot.
    int unsigned tot [NCH];
    int unsigned sh  [NCH];
    bit          held;

    function automatic logic [31:0] lo_of(input int unsigned t);
        return 32'(t % LO_MOD);
    endfunction

    function automatic logic [1:0] hi_of(input int unsigned t);
        return 2'((t / LO_MOD) % HI_MOD);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, push the expected
    // post-edge outputs, then advance to the next falling edge.
    task automatic cycle(input logic [3:0] ev, input logic frz, input logic ce,
                         input logic [3:0] cm, input logic sr, input logic sa,
                         input logic [1:0] sel, input logic r);
        exp_t        e;
        bit          held_n;
        int unsigned src;
        ev_inc = ev; freeze = frz; clr_en = ce; clr_mask = cm;
        snap_req = sr; snap_ack = sa; rd_sel = sel; rst = r;
        if (r) begin
            for (int i = 0; i < NCH; i++) begin
                tot[i] = 0;
                sh[i]  = 0;
            end
            held = 1'b0;
            e.lo = '0; e.hi = '0; e.lo_b = '0; e.hi_b = '0;
        end else begin
            src  = held ? sh[sel] : tot[sel];
            e.lo = lo_of(src);
            e.hi = hi_of(src);
            if (sel >= 2'd3) begin
                e.lo_b = '0;
                e.hi_b = '0;
            end else begin
                e.lo_b = e.lo;
                e.hi_b = e.hi;
            end
            held_n = held;
            if (!held && sr) begin
                for (int i = 0; i < NCH; i++) sh[i] = tot[i];
                held_n = 1'b1;
            end else if (held && sa) begin
                held_n = 1'b0;
            end
            for (int i = 0; i < NCH; i++) begin
                if (ce && cm[i]) tot[i] = 0;
                else if (ev[i] && !frz) tot[i] = tot[i] + 1;
            end
            held = held_n;
        end
        e.sv = held;
        for (int i = 0; i < NCH; i++) e.ovf[i] = (tot[i] >= OVF_AT);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input logic [1:0] sel);
        cycle(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, sel, 1'b0);
    endtask

    task automatic evs(input logic [3:0] ev, input int n, input logic [1:0] sel);
        for (int k = 0; k < n; k++) cycle(ev, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, sel, 1'b0);
    endtask

    // Monitor: compare both instances against the queued expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rd_lo",        rd_lo,              e.lo);
                check("rd_hi",        32'(rd_hi),         32'(e.hi));
                check("snap_valid",   32'(snap_valid),    32'(e.sv));
                check("ovf",          32'(ovf),           32'(e.ovf));
                check("b_rd_lo",      rd_lo_b,            e.lo_b);
                check("b_rd_hi",      32'(rd_hi_b),       32'(e.hi_b));
                check("b_snap_valid", 32'(snap_valid_b),  32'(e.sv));
                check("b_ovf",        32'(ovf_b),         32'(e.ovf[2:0]));
            end
        end
    end

    initial begin : driver
        logic [3:0] r_ev, r_cm;
        logic       r_frz, r_ce, r_sr, r_sa, r_rst;
        logic [1:0] r_sel;
        @(negedge clk);

        // Reset state.
        cycle(4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        cycle(4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        check("reset_rd_lo", rd_lo, 32'd0);
        check("reset_snap_valid", 32'(snap_valid), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);

        // Low counter wraps into high counter.
        evs(4'b0001, 10, 2'd0);
        idle(2'd0);
        check("wrap_lo", rd_lo, 32'd0);
        check("wrap_hi", 32'(rd_hi), 32'd1);
        check("wrap_ovf", 32'(ovf), 32'd0);

        // High counter wraps and sets sticky overflow.
        evs(4'b0010, 40, 2'd1);
        idle(2'd1);
        check("ovf_lo", rd_lo, 32'd0);
        check("ovf_hi", 32'(rd_hi), 32'd0);
        check("ovf_flag", 32'(ovf), 32'b0010);
        evs(4'b0010, 5, 2'd1);
        idle(2'd1);
        check("ovf_sticky_lo", rd_lo, 32'd5);
        check("ovf_sticky_flag", 32'(ovf), 32'b0010);

        // Clear beats a same-cycle increment; other channels untouched.
        evs(4'b0100, 7, 2'd2);
        cycle(4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 2'd2, 1'b0);
        idle(2'd2);
        check("clr_lo", rd_lo, 32'd0);
        check("clr_hi", 32'(rd_hi), 32'd0);
        check("clr_ovf", 32'(ovf), 32'b0010);
        idle(2'd0);
        check("clr_other_hi", 32'(rd_hi), 32'd1);

        // Snapshot holds the captured value while live counting continues.
        cycle(4'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0);
        evs(4'b0001, 3, 2'd0);
        cycle(4'b0, 1'b0, 1'b0, 4'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        evs(4'b0001, 4, 2'd0);
        check("snap_valid_hold", 32'(snap_valid), 32'd1);
        check("snap_rd_lo", rd_lo, 32'd3);
        cycle(4'b0, 1'b0, 1'b0, 4'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        check("snap_req_ignored", rd_lo, 32'd3);
        cycle(4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        check("snap_ack_release", 32'(snap_valid), 32'd0);
        idle(2'd0);
        check("snap_live_after", rd_lo, 32'd7);

        // Freeze holds all counts; select channel 3.
        evs(4'b1000, 2, 2'd3);
        for (int k = 0; k < 5; k++)
            cycle(4'b1111, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 2'd3, 1'b0);
        idle(2'd3);
        check("freeze_ch3", rd_lo, 32'd2);
        idle(2'd0);
        check("freeze_ch0", rd_lo, 32'd7);

        // Reset in the middle of a held snapshot.
        cycle(4'b0, 1'b0, 1'b0, 4'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        cycle(4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        check("rst_hold_valid", 32'(snap_valid), 32'd0);
        check("rst_hold_ovf", 32'(ovf), 32'd0);
        check("rst_hold_rd_lo", rd_lo, 32'd0);
        cycle(4'b0, 1'b0, 1'b0, 4'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        evs(4'b0001, 4, 2'd0);
        check("rst_snap_valid", 32'(snap_valid), 32'd1);
        check("rst_snap_zero", rd_lo, 32'd0);
        cycle(4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        idle(2'd0);
        check("rst_live_after", rd_lo, 32'd4);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            r_ev  = 4'($urandom);
            r_frz = ($urandom_range(0, 7) == 0);
            r_ce  = ($urandom_range(0, 39) == 0);
            r_cm  = 4'($urandom);
            r_sr  = ($urandom_range(0, 7) == 0);
            r_sa  = ($urandom_range(0, 7) == 0);
            r_sel = 2'($urandom);
            r_rst = ($urandom_range(0, 499) == 0);
            cycle(r_ev, r_frz, r_ce, r_cm, r_sr, r_sa, r_sel, r_rst);
        end

        idle(2'd0);
        idle(2'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/perf_cnt_bank.md
PERF_CNT_BANK -- requirements
Module: perf_cnt_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 16, number of event channels (1..32).
REQ-002 SHALL have parameter LO_MAX, default 999999999, wrap limit of the low (decimal-digit) counter.
REQ-003 SHALL have parameter HI_W, default 32, high counter width; the low counter is fixed at 32 bits.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset; one clock, synchronous, active-high.
REQ-006 SHALL have port ev_inc  in  NUM_CH  per-channel event strobe, +1 per cycle when high.
REQ-007 SHALL have port freeze  in  1  suppresses all increments while high.
REQ-008 SHALL have port clr_en  in  1  clear strobe, qualified by clr_mask.
REQ-009 SHALL have port clr_mask  in  NUM_CH  channels to clear.
REQ-010 SHALL have port snap_req  in  1  request atomic snapshot of all channels.
REQ-011 SHALL have port snap_ack  in  1  releases the held snapshot.
REQ-012 SHALL have port snap_valid  out  1  snapshot held.
REQ-013 SHALL have port rd_sel  in  clog2(NUM_CH) (min 1)  read channel select.
REQ-014 SHALL have port rd_lo  out  32  selected low count.
REQ-015 SHALL have port rd_hi  out  HI_W  selected high count.
REQ-016 SHALL have port ovf  out  NUM_CH  sticky per-channel overflow flags, live.

Function
REQ-017 SHALL, per channel i, increment lo[i] by 1 in a cycle where ev_inc[i]=1 and freeze=0.
REQ-018 SHALL, on an increment with lo[i]==LO_MAX, set lo[i] to 0 and add 1 to hi[i] in the same edge; lo never exceeds LO_MAX.
REQ-019 SHALL, on a carry with hi[i] all-ones, wrap hi[i] to 0 and set ovf[i]; ovf[i] stays set until cleared or reset.
REQ-020 SHALL, when clr_en=1, zero lo, hi and ovf of every channel with clr_mask[i]=1 at the next edge; clear beats a same-cycle increment on that channel; unmasked channels are unaffected.
REQ-021 SHALL hold counts unchanged while freeze=1; clear still acts during freeze.
REQ-022 SHALL implement a two-state snapshot FSM: IDLE and HOLD; snap_valid=1 exactly in HOLD.
REQ-023 SHALL, in IDLE with snap_req=1, copy all lo/hi values as they stand before that edge into shadow registers and enter HOLD; count updates at that same edge are not in the snapshot.
REQ-024 SHALL, in HOLD, ignore snap_req and leave the shadow registers unchanged; snap_ack=1 returns the FSM to IDLE at the next edge.
REQ-025 SHALL ignore snap_ack in IDLE and SHALL NOT capture on a same-cycle snap_req in HOLD; a new capture needs snap_req in IDLE.
REQ-026 SHALL register rd_lo/rd_hi with one-cycle latency: the value at edge t+1 reflects rd_sel at t, taken from shadow if in HOLD at t, else from the live counters.
REQ-027 SHALL return rd_lo=0 and rd_hi=0 for rd_sel >= NUM_CH.
REQ-028 SHALL apply a clear in HOLD to live counters only; the shadow registers keep the captured values.

Reset
REQ-029 SHALL, on rst, set all lo, hi, ovf, shadow registers, rd_lo and rd_hi to 0, set snap_valid to 0 and the FSM to IDLE; rst overrides every other input, including mid-snapshot.

Structure
REQ-030 SHALL place the FSM state encoding and the default LO_MAX constant in the shared CPU package.
REQ-031 SHALL use one sub-module, perf_cnt_chan (lo/hi/ovf for one channel, parameters LO_MAX and HI_W), instantiated NUM_CH times by a generate loop; the snapshot FSM and read mux stay in the top.
REQ-032 SHALL connect to the CPU as its cpu_perf_cnt_* outputs as {hi,lo} pairs, with ovf packed into one word.

Verification (bench uses NUM_CH=4, LO_MAX=9, HI_W=2)
REQ-033 Wrap: hold ev_inc[0] for 10 cycles from reset, rd_sel=0 -> rd_lo=0, rd_hi=1; ovf=0000.
REQ-034 Overflow: hold ev_inc[1] for 40 cycles -> lo=0, hi=0, ovf[1]=1; 5 more events -> lo=5, ovf[1] still 1.
REQ-035 Clear priority: ch2 at lo=7, then clr_en=1, clr_mask=0100 and ev_inc[2]=1 in the same cycle -> lo=0, hi=0, ovf[2]=0; ch0 unchanged.
REQ-036 Snapshot: ch0=3, pulse snap_req, then 4 more events -> snap_valid=1, rd_lo=3 from shadow; a second snap_req is ignored; snap_ack -> snap_valid=0 next cycle and the next read gives 7.
REQ-037 Freeze/select: freeze=1 with all ev_inc=1 for 5 cycles -> all counts unchanged; rd_sel=3 with ch3=2 -> rd_lo=2 one cycle later.
REQ-038 Reset mid-HOLD: counts nonzero and snap_valid=1, rst for 1 cycle -> all outputs 0, FSM in IDLE, and the next snap_req captures the post-reset zeros.
